// File: rtl/carfield_addr_rule_table.sv
// Runtime-programmable address rule table: register-programmed {base, size, enable, target}
// entries, lowest-index-wins lookup through one valid/ready registered stage.
module carfield_addr_rule_table #(
  parameter int unsigned NumRules   = 16,
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned TgtWidth   = 4,
  parameter logic [TgtWidth-1:0] DefaultTgt = '0,
  parameter int unsigned PageW      = $clog2(NumRules + 1),
  localparam int unsigned RuleW     = (NumRules > 1) ? $clog2(NumRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [PageW+1:0]     cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic                 resp_hit_o,
  output logic [TgtWidth-1:0]  resp_tgt_o,
  output logic [RuleW-1:0]     resp_rule_o,
  output logic                 locked_o,
  output logic [31:0]          miss_cnt_o
);

  localparam logic [PageW-1:0] GlobPage = PageW'(NumRules);

  logic [AddrWidth-1:0] base_q [NumRules];
  logic [AddrWidth-1:0] size_q [NumRules];
  logic [TgtWidth-1:0]  tgt_q  [NumRules];
  logic [NumRules-1:0]  en_q;
  logic                 lock_q;
  logic [31:0]          miss_q;

  logic [PageW-1:0]     cfg_page;
  logic [1:0]           cfg_word;
  logic [RuleW-1:0]     cfg_idx;
  logic                 rule_page, glob_page, bad_page;
  logic                 rule_wr, lock_set, cnt_clr, err_d;
  logic [AddrWidth-1:0] rdata_d;

  assign cfg_page  = cfg_addr_i[PageW+1:2];
  assign cfg_word  = cfg_addr_i[1:0];
  assign cfg_idx   = cfg_page[RuleW-1:0];
  assign rule_page = cfg_page < GlobPage;
  assign glob_page = cfg_page == GlobPage;
  assign bad_page  = cfg_page > GlobPage;

  assign rule_wr  = cfg_req_i && cfg_we_i && rule_page && !lock_q;
  assign lock_set = cfg_req_i && cfg_we_i && glob_page && (cfg_word == 2'd0) && cfg_wdata_i[0];
  assign cnt_clr  = cfg_req_i && cfg_we_i && glob_page && (cfg_word == 2'd1);
  assign err_d    = bad_page || (cfg_we_i && rule_page && lock_q);

  always_comb begin
    rdata_d = '0;
    if (!cfg_we_i) begin
      if (rule_page) begin
        case (cfg_word)
          2'd0: rdata_d = base_q[cfg_idx];
          2'd1: rdata_d = size_q[cfg_idx];
          2'd2: begin
            rdata_d[TgtWidth]     = en_q[cfg_idx];
            rdata_d[TgtWidth-1:0] = tgt_q[cfg_idx];
          end
          default: rdata_d = '0;
        endcase
      end else if (glob_page) begin
        case (cfg_word)
          2'd0:    rdata_d[0] = lock_q;
          2'd1:    rdata_d = AddrWidth'(miss_q);
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // Offset compare instead of base+size so a range that wraps past the top never matches low addresses.
  logic [NumRules-1:0] match;
  for (genvar i = 0; i < NumRules; i++) begin : g_match
    assign match[i] = en_q[i] && (size_q[i] != '0) && (req_addr_i >= base_q[i]) &&
                      ((req_addr_i - base_q[i]) < size_q[i]);
  end

  logic                hit_d;
  logic [TgtWidth-1:0] tgt_d;
  logic [RuleW-1:0]    rule_d;

  always_comb begin
    hit_d  = 1'b0;
    tgt_d  = DefaultTgt;
    rule_d = '0;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_d  = 1'b1;
        tgt_d  = tgt_q[i];
        rule_d = RuleW'(i);
      end
    end
  end

  logic accept;
  assign req_ready_o = !resp_valid_o || resp_ready_i;
  assign accept      = req_valid_i && req_ready_o;
  assign locked_o    = lock_q;
  assign miss_cnt_o  = miss_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NumRules); i++) begin
        base_q[i] <= '0;
        size_q[i] <= '0;
        tgt_q[i]  <= '0;
      end
      en_q         <= '0;
      lock_q       <= 1'b0;
      miss_q       <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
      cfg_rdata_o  <= '0;
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_tgt_o   <= '0;
      resp_rule_o  <= '0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && err_d;
      cfg_rdata_o  <= cfg_req_i ? rdata_d : '0;

      if (rule_wr) begin
        case (cfg_word)
          2'd0: base_q[cfg_idx] <= cfg_wdata_i;
          2'd1: size_q[cfg_idx] <= cfg_wdata_i;
          2'd2: begin
            en_q[cfg_idx]  <= cfg_wdata_i[TgtWidth];
            tgt_q[cfg_idx] <= cfg_wdata_i[TgtWidth-1:0];
          end
          default: ;
        endcase
      end
      if (lock_set) lock_q <= 1'b1;

      if (cnt_clr) begin
        miss_q <= '0;
      end else if (accept && !hit_d && (miss_q != '1)) begin
        miss_q <= miss_q + 32'd1;
      end

      if (accept) begin
        resp_valid_o <= 1'b1;
        resp_hit_o   <= hit_d;
        resp_tgt_o   <= tgt_d;
        resp_rule_o  <= rule_d;
      end else if (resp_ready_i) begin
        resp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carfield_addr_rule_table.sv
// Scoreboard bench for carfield_addr_rule_table: a reference table model predicts each lookup
// result at handshake time; a monitor pops and compares when the response is consumed.
module tb_carfield_addr_rule_table;

  localparam int N  = 16;
  localparam int AW = 64;
  localparam int TW = 4;
  localparam int PW = 5;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_req, cfg_we;
  logic [PW+1:0] cfg_addr;
  logic [AW-1:0] cfg_wdata, cfg_rdata;
  logic          cfg_rvalid, cfg_err;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid, resp_ready, resp_hit;
  logic [TW-1:0] resp_tgt;
  logic [RW-1:0] resp_rule;
  logic          locked;
  logic [31:0]   miss_cnt;

  always #5 clk = ~clk;

  carfield_addr_rule_table #(
    .NumRules(N), .AddrWidth(AW), .TgtWidth(TW), .DefaultTgt(4'd0), .PageW(PW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
    .resp_tgt_o(resp_tgt), .resp_rule_o(resp_rule),
    .locked_o(locked), .miss_cnt_o(miss_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the table; lookups use a widened end address rather than an offset.
  logic [63:0] m_base [N];
  logic [63:0] m_size [N];
  logic        m_en   [N];
  logic [3:0]  m_tgt  [N];
  logic        m_lock;
  logic [31:0] m_miss;
  logic [8:0]  sb [$];
  string       cur_test = "reset";

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_base[i] = '0; m_size[i] = '0; m_en[i] = 1'b0; m_tgt[i] = '0;
    end
    m_lock = 1'b0;
    m_miss = '0;
  endtask

  function automatic logic [8:0] model_lookup(logic [63:0] a);
    logic [64:0] last;
    for (int i = 0; i < N; i++) begin
      last = {1'b0, m_base[i]} + {1'b0, m_size[i]};
      if (m_en[i] && m_size[i] != 0 && a >= m_base[i] && {1'b0, a} < last)
        return {1'b1, m_tgt[i], 4'(i)};
    end
    return {1'b0, 4'd0, 4'd0};
  endfunction

  function automatic logic [63:0] model_read(int page, int word);
    if (page < N) begin
      if (word == 0) return m_base[page];
      if (word == 1) return m_size[page];
      if (word == 2) return {59'd0, m_en[page], m_tgt[page]};
      return 64'd0;
    end
    if (page == N) begin
      if (word == 0) return {63'd0, m_lock};
      if (word == 1) return {32'd0, m_miss};
    end
    return 64'd0;
  endfunction

  task automatic model_write(int page, int word, logic [63:0] d);
    if (page < N && !m_lock) begin
      if (word == 0) m_base[page] = d;
      if (word == 1) m_size[page] = d;
      if (word == 2) begin m_en[page] = d[4]; m_tgt[page] = d[3:0]; end
    end else if (page == N) begin
      if (word == 0 && d[0]) m_lock = 1'b1;
      if (word == 1) m_miss = '0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the response cycle.
  task automatic cfg_access(logic we, int page, int word, logic [63:0] d, string tag);
    logic [63:0] er;
    logic        ee;
    er = we ? 64'd0 : model_read(page, word);
    ee = (page > N) || (we && page < N && m_lock);
    cfg_req = 1'b1; cfg_we = we; cfg_addr = {PW'(page), 2'(word)}; cfg_wdata = d;
    @(posedge clk); #1;
    cfg_req = 1'b0;
    if (we) model_write(page, word, d);
    check_val({tag, "_rvalid"}, cfg_rvalid, 1);
    check_val({tag, "_err"}, cfg_err, ee);
    if (!we) check_val({tag, "_rdata"}, cfg_rdata, er);
  endtask

  task automatic program_rule(int r, logic [63:0] b, logic [63:0] s, logic [63:0] w2);
    cfg_access(1'b1, r, 0, b, "prog_base");
    cfg_access(1'b1, r, 1, s, "prog_size");
    cfg_access(1'b1, r, 2, w2, "prog_ctl");
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back.
  task automatic lookup(logic [63:0] a);
    logic [8:0] e;
    bit ok = 0;
    req_valid = 1'b1; req_addr = a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check_val({cur_test, "_req_timeout"}, 0, 1);
      req_valid = 1'b0;
      return;
    end
    e = model_lookup(a);
    sb.push_back(e);
    if (!e[8] && m_miss != 32'hFFFF_FFFF) m_miss++;
    @(posedge clk); #1;
    check_val({cur_test, "_latency"}, resp_valid, 1);
  endtask

  task automatic req_idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check_val({cur_test, "_drained"}, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) check_val({cur_test, "_resp_unexpected"}, 1, 0);
      else check_val({cur_test, "_resp"}, {resp_hit, resp_tgt, resp_rule}, sb.pop_front());
    end
  end

  initial begin
    logic [8:0] e;
    rst = 1'b1; cfg_req = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    req_valid = 0; req_addr = '0; resp_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_resp_valid", resp_valid, 0);
    check_val("rst_cfg_rvalid", cfg_rvalid, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_miss", miss_cnt, 0);
    check_val("rst_resp_fields", {resp_hit, resp_tgt, resp_rule}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    cur_test = "single";
    program_rule(0, 64'h7800_0000, 64'h20_0000, 64'h11);
    cfg_access(1'b0, 0, 2, 0, "single_rd_ctl");
    lookup(64'h7800_0000);
    lookup(64'h781F_FFFF);
    lookup(64'h7820_0000);
    req_idle();
    drain();
    check_val("single_miss_cnt", miss_cnt, m_miss);

    cur_test = "overlap";
    program_rule(3, 64'h5000_0000, 64'h80_0000, 64'h15);
    program_rule(1, 64'h5000_0000, 64'h100_0000, 64'h12);
    lookup(64'h5010_0000);
    lookup(64'h5000_0000);
    lookup(64'h5090_0000);
    lookup(64'h5100_0000);
    req_idle();
    drain();

    cur_test = "overflow";
    program_rule(0, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 64'h11);
    lookup(64'h0);
    lookup(64'hFFF);
    lookup(64'hFFFF_FFFF_FFFF_FFF0);
    req_idle();
    drain();
    check_val("overflow_miss_cnt", miss_cnt, m_miss);

    cur_test = "backpressure";
    resp_ready = 1'b0;
    lookup(64'h5010_0000);
    req_valid = 1'b1; req_addr = 64'hFFFF_FFFF_FFFF_F800;
    e = sb[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_ready_low", req_ready, 0);
      check_val("bp_valid_held", resp_valid, 1);
      check_val("bp_fields_stable", {resp_hit, resp_tgt, resp_rule}, e);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    lookup(64'hFFFF_FFFF_FFFF_F800);
    lookup(64'h9000_0000);
    req_idle();
    drain();
    check_val("bp_miss_cnt", miss_cnt, m_miss);

    cur_test = "collision";
    program_rule(2, 64'h6000_0000, 64'h1000, 64'h07);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = {5'd2, 2'd2}; cfg_wdata = 64'h17;
    req_valid = 1'b1; req_addr = 64'h6000_0010;
    @(negedge clk);
    check_val("coll_ready", req_ready, 1);
    e = model_lookup(64'h6000_0010);
    sb.push_back(e);
    if (!e[8]) m_miss++;
    @(posedge clk); #1;
    model_write(2, 2, 64'h17);
    cfg_req = 1'b0; req_valid = 1'b0;
    check_val("coll_cfg_err", cfg_err, 0);
    lookup(64'h6000_0010);
    req_idle();
    drain();

    cur_test = "lock";
    cfg_access(1'b1, N, 0, 64'h1, "lock_set");
    check_val("lock_locked", locked, 1);
    cfg_access(1'b1, 0, 0, 64'h1234, "lock_wr_base");
    cfg_access(1'b0, 0, 0, 0, "lock_rd_base");
    cfg_access(1'b1, N, 0, 64'h0, "lock_wr0");
    cfg_access(1'b0, N, 0, 0, "lock_rd_lock");
    cfg_access(1'b0, N, 1, 0, "lock_rd_miss");
    cfg_access(1'b1, N, 1, 64'hDEAD, "lock_clr_miss");
    check_val("lock_miss_cleared", miss_cnt, 0);
    cfg_access(1'b0, N, 1, 0, "lock_rd_miss0");
    cfg_access(1'b0, N + 1, 0, 0, "lock_bad_rd");
    cfg_access(1'b1, N + 1, 0, 64'h5, "lock_bad_wr");
    cfg_access(1'b0, 1, 3, 0, "lock_rd_rsvd");
    lookup(64'h6000_0020);
    req_idle();
    drain();

    cur_test = "reset";
    resp_ready = 1'b0;
    lookup(64'h5010_0000);
    req_idle();
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_resp_valid", resp_valid, 0);
    check_val("rst_mid_locked", locked, 0);
    check_val("rst_mid_miss", miss_cnt, 0);
    rst = 1'b0;
    sb.delete();
    model_reset();
    resp_ready = 1'b1;
    cfg_access(1'b0, 1, 0, 0, "rst_rd_base");
    cfg_access(1'b0, 1, 2, 0, "rst_rd_ctl");
    lookup(64'h5010_0000);
    req_idle();
    drain();
    check_val("rst_final_miss", miss_cnt, m_miss);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
